button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Conditions raw push-button inputs before they reach the seven-segment counter/display logic. Each button gets:
- a 2-flop synchroniser;
- a debounce filter;
- a press/hold/auto-repeat state machine.

Outputs are clean single-cycle press, repeat and release pulses, plus a debounced level. Downstream logic can therefore increment a number or step the scan speed once per press, or repeatedly while the button is held.

Parameters:
NUM_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a press or release (10 ms at 50 MHz)
REPEAT_DELAY, 25000000, held cycles after the accepted press before the first repeat pulse (500 ms)
REPEAT_RATE, 5000000, cycles between successive repeat pulses (100 ms)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed
repeat_en  input  NUM_BTN  per-channel auto-repeat enable, sampled synchronously
btn_level  output  NUM_BTN  debounced button state
btn_pulse  output  NUM_BTN  1-cycle pulse on accepted press and on every repeat
btn_release  output  NUM_BTN  1-cycle pulse on accepted release

Behaviour:
Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset:
- Asserting rst_n at any time clears all sync flops, counters and outputs to 0, and forces every channel to IDLE. This also applies mid-operation.
- A button held through reset release is treated as a new press: btn_pulse fires after normal debounce.

Channels:
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- s denotes the 2-flop synchronised btn_raw bit. cnt is the per-channel counter, width $clog2(max of the three timing parameters).

States (per channel):
- IDLE (level 0): s=1 -> PRESS_DB, cnt=0.
- PRESS_DB: s=0 -> IDLE (bounce rejected, no output). cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level=1, btn_pulse=1, cnt=0. Otherwise cnt++.
- HELD: s=0 -> RELEASE_DB, cnt=0. repeat_en=0 -> cnt held at 0. repeat_en=1 and cnt==REPEAT_DELAY-1 -> REPEAT, btn_pulse=1, cnt=0. Otherwise cnt++.
- REPEAT: s=0 -> RELEASE_DB, cnt=0. repeat_en=0 -> HELD, cnt=0, no pulse. cnt==REPEAT_RATE-1 -> btn_pulse=1, cnt=0. Otherwise cnt++.
- RELEASE_DB (btn_level stays 1): s=1 -> HELD, cnt=0, no pulse; the repeat delay restarts. cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0, btn_release=1. Otherwise cnt++.

Outputs and timing:
- All outputs are registered.
- btn_pulse and btn_release are exactly one cycle wide and never asserted in the same cycle on the same channel.
- Latency: if btn_raw rises and stays stable before edge 1, btn_pulse is high in the cycle after edge DEBOUNCE_CYCLES+3. The same latency applies from a btn_raw fall to btn_release.
- Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produce no output and no level change.
- Counters never wrap: every counting state exits or clears cnt at its terminal value.
- Parameter constraints: all three timing parameters must be >= 2. Changing repeat_en mid-count takes effect on the next edge.

Decomposition:
Package button_pkg contains:
- the channel state encoding (IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB), 3 bits;
- the default timing constants;
- a function computing counter width from the parameters.

Sub-module button_channel holds one synchroniser, the FSM and the counter. The top level instantiates it NUM_BTN times in a generate loop and only concatenates per-channel outputs.

Test Plan:
Use NUM_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3 for all scenarios.
1. Clean press: btn_raw[0] 0->1, held 20 cycles with repeat_en=0 -> btn_pulse[0] high exactly one cycle, after edge 7; btn_level[0]=1 from then on; no further pulses.
2. Bounce: btn_raw[0] toggles 1,0,1,0 with 2-cycle highs, then stays 0 -> btn_pulse, btn_level and btn_release all stay 0.
3. Release: from scenario 1, btn_raw[0] -> 0 -> btn_release[0] one cycle after edge 7; btn_level[0]=0 in that same cycle.
4. Auto-repeat: repeat_en[0]=1, hold 30 cycles -> press pulse at edge 7, repeats at edges 17, 20, 23, 26, 29; drop repeat_en at edge 24 -> no pulse at 26 or later.
5. Simultaneous: both btn_raw bits rise on the same cycle -> btn_pulse=2'b11 for the same single cycle.
6. Reset mid-hold: assert rst_n=0 while in REPEAT with the button still held -> all outputs 0 immediately. Release reset with btn_raw=1 -> new btn_pulse after edge 7 relative to reset release.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared state encoding, default timing and counter sizing for the button conditioner
package button_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    // Counter only ever reaches (limit - 1), so $clog2 of the largest limit suffices
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce and press/hold/auto-repeat FSM for one button
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

    logic [1:0]    sync;
    logic          s;
    btn_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pulse_n, rel_n;

    assign s = sync[1];

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btn_raw};
    end

    // State, counter and registered outputs; level follows the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            btn_level   <= state_n inside {HELD, REPEAT, RELEASE_DB};
            btn_pulse   <= pulse_n;
            btn_release <= rel_n;
        end
    end

    // Next state: every counting state either exits or clears cnt at its terminal value
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        rel_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (s) state_n = PRESS_DB;
            end
            PRESS_DB: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = HELD;
                    pulse_n = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            HELD: begin
                if (!s) begin
                    state_n = RELEASE_DB;
                    cnt_n   = '0;
                end else if (!repeat_en) cnt_n = '0;
                else if (cnt == RD_LAST) begin
                    state_n = REPEAT;
                    pulse_n = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            REPEAT: begin
                if (!s) begin
                    state_n = RELEASE_DB;
                    cnt_n   = '0;
                end else if (!repeat_en) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == RR_LAST) begin
                    pulse_n = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            RELEASE_DB: begin
                if (s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BTN independent debounced press/repeat/release channels
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[g]),
            .repeat_en  (repeat_en[g]),
            .btn_level  (btn_level[g]),
            .btn_pulse  (btn_pulse[g]),
            .btn_release(btn_release[g])
        );
    end

endmodule
